// File: rtl/fifo_thresh_if.sv
// Handshake/data bundle between a FIFO user (master) and the fifo_thresh
// storage block (slave). Carries write/read requests, flush and error clear
// toward the FIFO, and head data, occupancy, level flags and sticky errors back.
interface fifo_thresh_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
);
  logic                  flush;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  rd_en;
  logic                  clr_err;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [ADDR_WIDTH:0]   count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output flush, wr_en, wdata, rd_en, clr_err,
    input  rdata, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  flush, wr_en, wdata, rd_en, clr_err,
    output rdata, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/fifo_thresh.sv
// Synchronous show-ahead FIFO with almost-full/almost-empty thresholds and
// sticky overflow/underflow flags. Write-to-rdata latency 1 cycle; rdata is
// zero when empty. Full FIFO accepts a write only alongside an accepted read.
// Ports: clk, reset (sync, active-high), bus (slave side of fifo_thresh_if):
//   flush/wr_en/wdata/rd_en/clr_err in; rdata/full/empty/almost_full/
//   almost_empty/count/overflow/underflow out.
module fifo_thresh #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int AF_LEVEL   = 6,
  parameter int AE_LEVEL   = 2
) (
  input  logic           clk,
  input  logic           reset,
  fifo_thresh_if.slave   bus
);

  localparam logic [ADDR_WIDTH:0]   DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   AF_C    = (ADDR_WIDTH+1)'(AF_LEVEL);
  localparam logic [ADDR_WIDTH:0]   AE_C    = (ADDR_WIDTH+1)'(AE_LEVEL);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE = (ADDR_WIDTH+1)'(1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;

  logic full_w, empty_w, rd_acc, wr_acc;

  // Flags come only from the registered count.
  assign full_w  = (count_q == DEPTH_C);
  assign empty_w = (count_q == '0);

  // A full FIFO can still take a write when the head is popped the same cycle.
  assign rd_acc = bus.rd_en & ~empty_w & ~bus.flush;
  assign wr_acc = bus.wr_en & ~bus.flush & (~full_w | rd_acc);

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q & ~bus.clr_err;
    underflow_d = underflow_q & ~bus.clr_err;

    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (rd_acc) rd_ptr_d = rd_ptr_q + PTR_ONE;
      if (wr_acc && !rd_acc) count_d = count_q + CNT_ONE;
      else if (rd_acc && !wr_acc) count_d = count_q - CNT_ONE;
    end

    // Set events are applied after the clear so they win.
    if (bus.wr_en && full_w && !rd_acc && !bus.flush) overflow_d = 1'b1;
    if (bus.rd_en && empty_w && !bus.flush) underflow_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is not reset; rdata masking hides stale entries. Reset still
  // blocks the write so nothing commits during a reset cycle.
  always_ff @(posedge clk) begin
    if (!reset && wr_acc) mem_q[wr_ptr_q] <= bus.wdata;
  end

  assign bus.rdata        = empty_w ? '0 : mem_q[rd_ptr_q];
  assign bus.full         = full_w;
  assign bus.empty        = empty_w;
  assign bus.almost_full  = (count_q >= AF_C);
  assign bus.almost_empty = (count_q <= AE_C);
  assign bus.count        = count_q;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;

endmodule

// File: tb/tb_fifo_thresh.sv
module tb_fifo_thresh;
  localparam int DW = 8;
  localparam int DEPTH = 8;
  localparam int AW = 3;
  localparam int AF = 6;
  localparam int AE = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fifo_thresh_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  fifo_thresh #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW),
    .AF_LEVEL(AF), .AE_LEVEL(AE)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Reference model: a plain queue of stored bytes plus two sticky bits.
  logic [DW-1:0] mq[$];
  bit m_ovf = 1'b0;
  bit m_udf = 1'b0;

  always @(posedge clk) begin
    bit m_full, m_empty, m_rd, m_wr;
    if (reset) begin
      mq.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      m_full  = (mq.size() == DEPTH);
      m_empty = (mq.size() == 0);
      m_rd = bus.rd_en && !m_empty && !bus.flush;
      m_wr = bus.wr_en && !bus.flush && (!m_full || m_rd);
      if (bus.clr_err) begin
        m_ovf = 1'b0;
        m_udf = 1'b0;
      end
      if (bus.wr_en && m_full && !m_rd && !bus.flush) m_ovf = 1'b1;
      if (bus.rd_en && m_empty && !bus.flush) m_udf = 1'b1;
      if (bus.flush) mq.delete();
      else begin
        if (m_rd) void'(mq.pop_front());
        if (m_wr) mq.push_back(bus.wdata);
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      int n;
      n = mq.size();
      chk("count",        int'(bus.count), n);
      chk("rdata",        int'(bus.rdata), (n > 0) ? int'(mq[0]) : 0);
      chk("full",         int'(bus.full), int'(n == DEPTH));
      chk("empty",        int'(bus.empty), int'(n == 0));
      chk("almost_full",  int'(bus.almost_full), int'(n >= AF));
      chk("almost_empty", int'(bus.almost_empty), int'(n <= AE));
      chk("overflow",     int'(bus.overflow), int'(m_ovf));
      chk("underflow",    int'(bus.underflow), int'(m_udf));
    end
  end

  // Apply one cycle of inputs; returns 1 time unit after the edge.
  task automatic cyc(input bit w, input logic [DW-1:0] d, input bit r,
                     input bit f = 1'b0, input bit c = 1'b0, input bit rst = 1'b0);
    reset       = rst;
    bus.wr_en   = w;
    bus.wdata   = d;
    bus.rd_en   = r;
    bus.flush   = f;
    bus.clr_err = c;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, '0, 1'b0);
  endtask

  initial begin
    logic [DW-1:0] v;
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk_en = 1'b1;
    idle();

    // Reset state
    chk("rst_count", int'(bus.count), 0);
    chk("rst_empty", int'(bus.empty), 1);
    chk("rst_ae",    int'(bus.almost_empty), 1);
    chk("rst_full",  int'(bus.full), 0);
    chk("rst_af",    int'(bus.almost_full), 0);
    chk("rst_rdata", int'(bus.rdata), 0);

    // Fill 0x01..0x08
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b1, 8'(i), 1'b0);
      chk("fill_count", int'(bus.count), i);
      chk("fill_af", int'(bus.almost_full), (i >= 6) ? 1 : 0);
    end
    chk("fill_full", int'(bus.full), 1);
    cyc(1'b1, 8'h09, 1'b0);
    chk("ovf_set", int'(bus.overflow), 1);
    chk("ovf_count", int'(bus.count), 8);
    chk("ovf_head", int'(bus.rdata), 8'h01);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk("clr_ovf", int'(bus.overflow), 0);

    // Drain: expect 0x01..0x08 in order
    for (int i = 1; i <= 8; i++) begin
      chk("drain_rdata", int'(bus.rdata), i);
      cyc(1'b0, '0, 1'b1);
      chk("drain_ae", int'(bus.almost_empty), ((8 - i) <= 2) ? 1 : 0);
    end
    chk("drain_empty", int'(bus.empty), 1);
    cyc(1'b0, '0, 1'b1);
    chk("udf_set", int'(bus.underflow), 1);
    chk("udf_count", int'(bus.count), 0);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk("clr_udf", int'(bus.underflow), 0);

    // Empty read+write: write accepted, underflow flagged, no bypass
    chk("pre_rw_rdata", int'(bus.rdata), 0);
    cyc(1'b1, 8'h55, 1'b1);
    chk("erw_count", int'(bus.count), 1);
    chk("erw_udf",   int'(bus.underflow), 1);
    chk("erw_rdata", int'(bus.rdata), 8'h55);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);

    // Refill to full, then read+write 0xAA at full
    for (int i = 0; i < 7; i++) cyc(1'b1, 8'(8'h60 + i), 1'b0);
    chk("refill_full", int'(bus.full), 1);
    cyc(1'b1, 8'hAA, 1'b1);
    chk("frw_count", int'(bus.count), 8);
    chk("frw_head",  int'(bus.rdata), 8'h60);
    chk("frw_ovf",   int'(bus.overflow), 0);
    for (int i = 0; i < 8; i++) begin
      v = bus.rdata;
      cyc(1'b0, '0, 1'b1);
    end
    chk("frw_last", int'(v), 8'hAA);

    // Flush with concurrent write at count 5
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'h30 + i), 1'b0);
    chk("pre_flush_count", int'(bus.count), 5);
    cyc(1'b1, 8'hEE, 1'b0, 1'b1);
    chk("flush_count", int'(bus.count), 0);
    chk("flush_empty", int'(bus.empty), 1);

    // clr_err together with a rejected write keeps overflow
    for (int i = 0; i < 8; i++) cyc(1'b1, 8'(i), 1'b0);
    cyc(1'b1, 8'hFF, 1'b0);
    cyc(1'b1, 8'hFE, 1'b0, 1'b0, 1'b1);
    chk("clr_vs_set_ovf", int'(bus.overflow), 1);

    // Wrap: hold count at 3 for 20 read/write pairs
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'(8'hC0 + i), 1'b0);
    for (int i = 0; i < 20; i++) begin
      chk("wrap_head", int'(bus.rdata), 8'hC0 + i);
      cyc(1'b1, 8'(8'hC3 + i), 1'b1);
      chk("wrap_count", int'(bus.count), 3);
    end

    // Reset in the middle of traffic
    cyc(1'b1, 8'h77, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("midrst_count", int'(bus.count), 0);
    chk("midrst_rdata", int'(bus.rdata), 0);

    // Randomized traffic checked by the model
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 99) < 55), 8'($urandom_range(0, 255)),
          ($urandom_range(0, 99) < 50),
          ($urandom_range(0, 99) < 3),
          ($urandom_range(0, 99) < 5),
          ($urandom_range(0, 499) < 2));
    end
    idle();
    idle();
    chk_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
